// File: rtl/bomb_countdown_ctrl.sv
// Round supervisor: loads a difficulty-dependent M:SS countdown, decrements it once per second,
// and ends the round in DEFUSED (game win) or EXPLODED (game lose or timer expiry).
module bomb_countdown_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned EASY_SECS = 180,
  parameter int unsigned MED_SECS  = 120,
  parameter int unsigned HARD_SECS = 90
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] difficulty,
  input  logic       game_win,
  input  logic       game_lose,
  output logic [9:0] time_left,
  output logic [6:0] out_HEX_MIN,
  output logic [6:0] out_HEX_SECT,
  output logic [6:0] out_HEX_SECO,
  output logic       running,
  output logic       defused,
  output logic       exploded,
  output logic       beep
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TIME_W = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEFUSED,
    S_EXPLODED
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    tick_cnt, tick_cnt_nxt;
  logic [TIME_W-1:0]   time_nxt;
  logic                beep_nxt;
  logic                tick;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // State, counters and decoded flags; flags follow the next state so they align with it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      time_left <= '0;
      beep      <= 1'b0;
      running   <= 1'b0;
      defused   <= 1'b0;
      exploded  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      time_left <= time_nxt;
      beep      <= beep_nxt;
      running   <= (state_nxt == S_RUN);
      defused   <= (state_nxt == S_DEFUSED);
      exploded  <= (state_nxt == S_EXPLODED);
    end
  end

  // Next-state logic; lose beats win, win beats the tick that would expire the timer.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    time_nxt     = time_left;
    beep_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_RUN;
          tick_cnt_nxt = '0;
          case (difficulty)
            2'b00:   time_nxt = TIME_W'(EASY_SECS);
            2'b01:   time_nxt = TIME_W'(MED_SECS);
            default: time_nxt = TIME_W'(HARD_SECS);
          endcase
        end
      end
      S_RUN: begin
        tick_cnt_nxt = tick ? '0 : tick_cnt + CNT_W'(1);
        if (game_lose) begin
          state_nxt = S_EXPLODED;
        end else if (game_win) begin
          state_nxt = S_DEFUSED;
        end else if (time_left == '0) begin
          state_nxt = S_EXPLODED;
        end else if (tick) begin
          time_nxt = time_left - TIME_W'(1);
          beep_nxt = 1'b1;
          if (time_left == TIME_W'(1)) state_nxt = S_EXPLODED;
        end
      end
      default: ;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7f;
    endcase
  endfunction

  logic [TIME_W-1:0] secs;
  logic [3:0]        dig_min, dig_tens, dig_ones;

  // M:SS split of the remaining time for the display.
  always_comb begin
    secs     = time_left % TIME_W'(60);
    dig_min  = 4'(time_left / TIME_W'(60));
    dig_tens = 4'(secs / TIME_W'(10));
    dig_ones = 4'(secs % TIME_W'(10));
  end

  assign out_HEX_MIN  = seg7(dig_min);
  assign out_HEX_SECT = seg7(dig_tens);
  assign out_HEX_SECO = seg7(dig_ones);

endmodule
